// File: rtl/keccak_round_ctrl.sv
// Round sequencer for the masked Keccak-f[1600] core: steps round_number_o 1..NUM_ROUNDS, CYCLES_PER_ROUND cycles each.
// Latency: last round_en_o at accept+NUM_ROUNDS*CYCLES_PER_ROUND, done_valid_o one cycle later (plus stalled cycles).
// Backpressure: start accepted only in IDLE; done_valid_o held until done_ready_i; optional randomness stall freezes ROUND.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   start_valid_i / start_ready_o  permutation request handshake; load_o pulses on accept
//   round_number_o, phase_o        current round (0 outside ROUND) and cycle index within it
//   round_en_o                     state register captures the round output this cycle
//   busy_o                         high in ROUND and DONE
//   done_valid_o / done_ready_i    completion handshake
// Optional feature macro KECCAK_RAND_STALL_EN adds rand_valid_i / rand_ack_o: ROUND only
// advances on cycles where fresh mask randomness is present.
module keccak_round_ctrl #(
    parameter int NUM_ROUNDS       = 24,
    parameter int CYCLES_PER_ROUND = 2,
    parameter int PHASE_W          = (CYCLES_PER_ROUND > 1) ? $clog2(CYCLES_PER_ROUND) : 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
`ifdef KECCAK_RAND_STALL_EN
    input  logic               rand_valid_i,
    output logic               rand_ack_o,
`endif
    input  logic               start_valid_i,
    output logic               start_ready_o,
    output logic               load_o,
    output logic [4:0]         round_number_o,
    output logic [PHASE_W-1:0] phase_o,
    output logic               round_en_o,
    output logic               busy_o,
    output logic               done_valid_o,
    input  logic               done_ready_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(CYCLES_PER_ROUND - 1);
    localparam logic [4:0]         LAST_ROUND = 5'(NUM_ROUNDS);

    state_t             r_state;
    logic [4:0]         r_round;
    logic [PHASE_W-1:0] r_phase;
    logic               r_busy;
    logic               r_done_valid;

    logic w_adv;
    logic w_last_phase;
    logic w_start_ready;

    // Without the stall feature the round pipeline advances unconditionally.
`ifdef KECCAK_RAND_STALL_EN
    assign w_adv      = rand_valid_i;
    assign rand_ack_o = (r_state == S_ROUND) & rand_valid_i;
`else
    assign w_adv = 1'b1;
`endif

    // >= rather than == so an out-of-range phase can never run past the round end.
    assign w_last_phase  = (r_phase >= LAST_PHASE);
    assign w_start_ready = (r_state == S_IDLE);

    assign start_ready_o  = w_start_ready;
    assign load_o         = start_valid_i & w_start_ready;
    assign round_en_o     = (r_state == S_ROUND) & w_last_phase & w_adv;
    assign round_number_o = r_round;
    assign phase_o        = r_phase;
    assign busy_o         = r_busy;
    assign done_valid_o   = r_done_valid;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= S_IDLE;
            r_round      <= 5'd0;
            r_phase      <= '0;
            r_busy       <= 1'b0;
            r_done_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_valid_i) begin
                        r_state <= S_ROUND;
                        r_round <= 5'd1;
                        r_phase <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_ROUND: begin
                    if (w_adv) begin
                        if (w_last_phase) begin
                            r_phase <= '0;
                            if (r_round >= LAST_ROUND) begin
                                r_state      <= S_DONE;
                                r_round      <= 5'd0;
                                r_done_valid <= 1'b1;
                            end else begin
                                r_round <= r_round + 5'd1;
                            end
                        end else begin
                            r_phase <= r_phase + PHASE_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (done_ready_i) begin
                        r_state      <= S_IDLE;
                        r_busy       <= 1'b0;
                        r_done_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_round      <= 5'd0;
                    r_phase      <= '0;
                    r_busy       <= 1'b0;
                    r_done_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
